filter_delay_ram: RTL and testbench

- Parametrised circular sample delay line for the filter datapath, built on iCE40 4K block RAM tiles.
- Each accepted input sample is written at an auto-incrementing write pointer.
- A read request names a tap index k and returns the sample written k acceptances ago.
- Sits between the sample source and the FIR MAC sequencer; generalises the fixed 64-bit x 256 dual-port RAM to arbitrary width and depth, with pointer, fill and stale tracking.

---
 rtl/filter_delay_ram.sv | 136 +++++++++++++
 tb/tb_filter_delay_ram.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_delay_ram.sv
// Circular sample delay line on 256x16 block RAM tiles; a tap read returns the sample written k acceptances ago.
// Define FILTER_DELAY_RAM_DUAL_TAP_EN to add a second tap port (rd_tap_b/out_data_b/out_stale_b) on a duplicated tile array.
module filter_delay_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_tap,
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
  input  logic [AW-1:0]    rd_tap_b,
  output logic [WIDTH-1:0] out_data_b,
  output logic             out_stale_b,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_stale,
  output logic [AW-1:0]    fill
);

  localparam int COLS = WIDTH / 16;
  localparam int ROWS = 1 << (AW - 8);
  localparam logic [AW-1:0] FULL = {AW{1'b1}};
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif

  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    fill_reg;
  logic             s1_valid_reg;
  logic             out_valid_reg;
  logic             flush;
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    lane_tap   [NL];
  logic [WIDTH-1:0] lane_data  [NL];
  logic             lane_stale [NL];

  assign flush = rst | clr;
  assign wr_en = in_valid & ~flush;
  // Tile reads only advance for a live request, so out_data holds between pulses.
  assign rd_en = s1_valid_reg & ~flush;

  assign lane_tap[0] = rd_tap;
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
  assign lane_tap[1] = rd_tap_b;
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_reg      <= '0;
      fill_reg      <= '0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg  <= rd_req;
      out_valid_reg <= s1_valid_reg;
      if (in_valid) begin
        wptr_reg <= wptr_reg + AW'(1);
        if (fill_reg != FULL) fill_reg <= fill_reg + AW'(1);
      end
    end
  end

  genvar gl, gj, gi;
  generate
    for (gl = 0; gl < NL; gl++) begin : g_lane
      logic [AW-1:0]              addr_reg;
      logic [AW-1:0]              row_reg;
      logic                       stale_reg;
      logic                       ostale_reg;
      logic                       blank_reg;
      logic [ROWS-1:0][WIDTH-1:0] rowq;
      logic [WIDTH-1:0]           sel_data;

      // Address and stale use the pre-write pointer/fill of the request cycle.
      always_ff @(posedge clk) begin
        if (rd_req) begin
          addr_reg  <= wptr_reg - AW'(1) - lane_tap[gl];
          stale_reg <= (lane_tap[gl] >= fill_reg) || (lane_tap[gl] == FULL);
        end
        if (rst) begin
          ostale_reg <= 1'b0;
          blank_reg  <= 1'b1;
          row_reg    <= '0;
        end else if (rd_en) begin
          ostale_reg <= stale_reg;
          blank_reg  <= stale_reg;
          row_reg    <= addr_reg >> 8;
        end
      end

      for (gj = 0; gj < ROWS; gj++) begin : g_row
        for (gi = 0; gi < COLS; gi++) begin : g_col
          logic [15:0] mem [256];
          logic [15:0] q_reg;

          // Read-first: a slot overwritten in the read cycle still returns its old sample.
          always_ff @(posedge clk) begin
            if (wr_en && ((wptr_reg >> 8) == AW'(gj)))
              mem[wptr_reg[7:0]] <= in_data[16*gi +: 16];
            if (rd_en)
              q_reg <= mem[addr_reg[7:0]];
          end

          assign rowq[gj][16*gi +: 16] = q_reg;
        end
      end

      always_comb begin
        sel_data = '0;
        for (int r = 0; r < ROWS; r++)
          if (row_reg == AW'(r)) sel_data = rowq[r];
      end

      assign lane_data[gl]  = blank_reg ? '0 : sel_data;
      assign lane_stale[gl] = ostale_reg;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_data  = lane_data[0];
  assign out_stale = lane_stale[0];
  assign fill      = fill_reg;
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
  assign out_data_b  = lane_data[1];
  assign out_stale_b = lane_stale[1];
`endif

endmodule

// File: tb/tb_filter_delay_ram.sv
// Scoreboard bench for filter_delay_ram: a sample-history reference model predicts each tap read.
module tb_filter_delay_ram;
  localparam int W  = 64;
  localparam int AW = 8;
  localparam int D  = 256;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, rd_req;
  logic [W-1:0]  in_data;
  logic [AW-1:0] rd_tap;
  logic [AW-1:0] tb_tap_b;
  logic          out_valid, out_stale;
  logic [W-1:0]  out_data;
  logic [AW-1:0] fill;
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
  logic [W-1:0]  out_data_b;
  logic          out_stale_b;
`endif

  always #5 clk = ~clk;

  filter_delay_ram #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .rd_req(rd_req), .rd_tap(rd_tap),
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
    .rd_tap_b(tb_tap_b), .out_data_b(out_data_b), .out_stale_b(out_stale_b),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_stale(out_stale), .fill(fill)
  );

  typedef struct {
    int           due;
    int           tap;
    logic [W-1:0] d;
    logic         s;
    logic [W-1:0] db;
    logic         sb;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] hist[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           run_mon = 1'b0;
  bit           hold_ok = 1'b0;
  logic [W-1:0] last_d;
  logic         last_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Tap k is the k-th most recent sample since the last reset/clr; the oldest slot is never readable.
  function automatic void model_read(input int k, output logic [W-1:0] d, output logic s);
    if (k >= hist.size() || k == D - 1) begin
      d = '0;
      s = 1'b1;
    end else begin
      d = hist[hist.size() - 1 - k];
      s = 1'b0;
    end
  endfunction

  task automatic step(input bit r_rst, input bit c_clr, input bit w, input logic [W-1:0] wd,
                      input bit r, input int k, input int kb);
    exp_t e;
    rst = r_rst; clr = c_clr; in_valid = w; in_data = wd; rd_req = r;
    rd_tap = AW'(k); tb_tap_b = AW'(kb);
    @(posedge clk);
    if (r_rst || c_clr) begin
      hist.delete();
      while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
      if (r_rst) begin
        last_d = '0; last_s = 1'b0; hold_ok = 1'b1;
      end else begin
        hold_ok = 1'b0;
      end
    end else begin
      if (r) begin
        e.due = cyc + 2;
        e.tap = k;
        model_read(k, e.d, e.s);
        model_read(kb, e.db, e.sb);
        sb_q.push_back(e);
      end
      if (w) begin
        hist.push_back(wd);
        if (hist.size() > D) void'(hist.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   fe;
    if (run_mon) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 64'(out_valid), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("latency", 64'(cyc), 64'(e.due));
          check("out_data", out_data, e.d);
          check("out_stale", 64'(out_stale), 64'(e.s));
`ifdef FILTER_DELAY_RAM_DUAL_TAP_EN
          check("out_data_b", out_data_b, e.db);
          check("out_stale_b", 64'(out_stale_b), 64'(e.sb));
`endif
          $display("rd cycle=%0d tap=%0d data=%h stale=%0b", cyc, e.tap, out_data, out_stale);
          last_d = e.d; last_s = e.s; hold_ok = 1'b1;
        end
      end else begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          check("missing_valid", 64'(out_valid), 64'(1));
          void'(sb_q.pop_front());
        end
        if (hold_ok) begin
          check("hold_data", out_data, last_d);
          check("hold_stale", 64'(out_stale), 64'(last_s));
        end
      end
      fe = (hist.size() > D - 1) ? D - 1 : hist.size();
      check("fill", 64'(fill), 64'(fe));
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0;
    rd_tap = '0; tb_tap_b = '0;
    @(posedge clk); #1;
    step(1, 0, 0, '0, 0, 0, 0);
    run_mon = 1'b1;
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);

    // Five writes, then taps 0, 4 and the first stale tap 5
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 64'(i), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 4, 0);
    step(0, 0, 0, '0, 1, 5, 0);
    repeat (3) step(0, 0, 0, '0, 0, 0, 0);

    // Wrap-around and fill saturation
    step(0, 1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 64'(i), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 254, 0);
    step(0, 0, 0, '0, 1, 255, 0);
    repeat (3) step(0, 0, 0, '0, 0, 0, 0);

    // Simultaneous write and read sees the pre-write state
    step(0, 0, 1, 64'h55, 0, 0, 0);
    step(0, 0, 1, 64'hAA, 1, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    repeat (3) step(0, 0, 0, '0, 0, 0, 0);

    // Back-to-back reads, then clr while reads are in flight
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, i, 0);
    repeat (2) step(0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 1, 0);
    step(0, 1, 0, '0, 1, 2, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    repeat (3) step(0, 0, 0, '0, 0, 0, 0);

    // Symmetric tap pair
    step(0, 1, 0, '0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, 64'(i), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 9);
    repeat (3) step(0, 0, 0, '0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      bit r_rst, c_clr, w, r;
      int k, kb;
      r_rst = ($urandom_range(0, 699) == 0);
      c_clr = ($urandom_range(0, 399) == 0);
      w     = ($urandom_range(0, 9) < 7);
      r     = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       k = $urandom_range(0, 15);
        1:       k = $urandom_range(250, 255);
        default: k = $urandom_range(0, 255);
      endcase
      kb = $urandom_range(0, 255);
      step(r_rst, c_clr, w, {$urandom, $urandom}, r, k, kb);
    end

    repeat (4) step(0, 0, 0, '0, 0, 0, 0);
    check("drain", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
